fp_addsub_seq: RTL and testbench



---
 rtl/fp_addsub_pkg.sv | 41 ++++
 rtl/fp_addsub_seq_shifter.sv | 36 +++
 rtl/fp_addsub_seq.sv | 208 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared constants for the sequential floating-point adder/subtractor:
// FSM state codes, op encoding, flag positions and special-value builder.
package fp_addsub_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ALIGN = 3'd1;
   localparam state_t ST_ADD   = 3'd2;
   localparam state_t ST_NORM  = 3'd3;
   localparam state_t ST_ROUND = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int FLAG_INVALID  = 3;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_INEXACT  = 1;
   localparam int FLAG_ZERO     = 0;

   localparam logic [3:0] FLG_INVALID  = 4'b0001 << FLAG_INVALID;
   localparam logic [3:0] FLG_OVERFLOW = 4'b0001 << FLAG_OVERFLOW;
   localparam logic [3:0] FLG_INEXACT  = 4'b0001 << FLAG_INEXACT;
   localparam logic [3:0] FLG_ZERO     = 4'b0001 << FLAG_ZERO;

   localparam int FP_MAX_W = 128;

   // Canonical quiet NaN (sign 0, mantissa MSB set) or signed infinity,
   // returned right-aligned in a wide vector; callers slice their own width.
   function automatic logic [FP_MAX_W-1:0] fp_special(input int exp_w, input int man_w,
                                                      input logic is_nan, input logic sign);
      logic [FP_MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
      if (is_nan) v[man_w - 1] = 1'b1;
      else        v[exp_w + man_w] = sign;
      return v;
   endfunction

endpackage

// File: rtl/fp_addsub_seq_shifter.sv
// Barrel right shifter used for exponent alignment; every bit shifted out
// is collected into a single sticky bit.
module fp_align_shifter #(
   parameter int WIDTH = 15,
   parameter int AMT_W = 5
) (
   input  logic [WIDTH-1:0] din,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] dout,
   output logic             sticky
);

   localparam int SHW = $clog2(WIDTH + 2);

   logic [SHW-1:0] amt_sat;

   // Anything beyond WIDTH+1 behaves identically, so the stages stay narrow.
   always_comb begin
      if (32'(amt) > WIDTH + 1) amt_sat = SHW'(WIDTH + 1);
      else                      amt_sat = SHW'(amt);
   end

   always_comb begin
      dout   = din;
      sticky = 1'b0;
      for (int s = 0; s < SHW; s++) begin
         if (amt_sat[s]) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (i < (1 << s)) sticky = sticky | dout[i];
            end
            dout = dout >> (1 << s);
         end
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with RNE rounding, FTZ on both
// inputs and outputs, and valid/ready handshakes on each side.
//
// state    | meaning
// IDLE     | waiting for operands, in_ready high
// ALIGN    | classify, resolve specials, order and align mantissas
// ADD      | add or subtract aligned mantissas, detect exact zero
// NORM     | one normalisation step per cycle, underflow flush
// ROUND    | round to nearest even, overflow to infinity
// DONE     | result held with out_valid until out_ready
module fp_addsub_seq
   import fp_addsub_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int FW = EXP_W + MAN_W + 1;
   localparam int MW = MAN_W + 5;

   localparam logic [FP_MAX_W-1:0] NAN_FULL = fp_special(EXP_W, MAN_W, 1'b1, 1'b0);
   localparam logic [FP_MAX_W-1:0] INF_FULL = fp_special(EXP_W, MAN_W, 1'b0, 1'b0);
   localparam logic [FW-1:0]       QNAN     = NAN_FULL[FW-1:0];
   localparam logic [FW-2:0]       INF_MAG  = INF_FULL[FW-2:0];
   localparam logic [EXP_W:0]      EXP_MAX  = {1'b0, {EXP_W{1'b1}}};

   state_t           state;
   logic [FW-1:0]    a_q, b_q;
   logic             op_q;
   logic             sign_r;
   logic             eff_sub_r;
   logic [EXP_W:0]   exp_r;
   logic [MW-1:0]    mant_r, mant_sml;

   logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
   logic [EXP_W-1:0] ea, eb, big_e, sml_e, diff;
   logic [MAN_W-1:0] ma, mb, big_m, sml_m;
   logic [MW-1:0]    sml_pre, sml_shift, sum;
   logic             sml_sticky;
   logic             spec_hit;
   logic [FW-1:0]    spec_res;
   logic [3:0]       spec_flags;

   logic             rnd_g, rnd_r, rnd_s, rnd_inc, rnd_ovf;
   logic [MAN_W+1:0] rnd;
   logic [EXP_W:0]   exp_f;
   logic [MAN_W-1:0] man_f;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   // b's sign is inverted here for subtraction; everything downstream sees an add.
   assign sa     = a_q[FW-1];
   assign sb     = b_q[FW-1] ^ (op_q == OP_SUB);
   assign ea     = a_q[FW-2:MAN_W];
   assign eb     = b_q[FW-2:MAN_W];
   assign ma     = a_q[MAN_W-1:0];
   assign mb     = b_q[MAN_W-1:0];
   assign a_nan  = (&ea) && (|ma);
   assign b_nan  = (&eb) && (|mb);
   assign a_inf  = (&ea) && !(|ma);
   assign b_inf  = (&eb) && !(|mb);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_big  = {ea, ma} >= {eb, mb};
   assign big_e  = a_big ? ea : eb;
   assign sml_e  = a_big ? eb : ea;
   assign big_m  = a_big ? ma : mb;
   assign sml_m  = a_big ? mb : ma;
   assign diff   = big_e - sml_e;
   assign sml_pre = {2'b01, sml_m, 3'b000};

   fp_align_shifter #(.WIDTH(MW), .AMT_W(EXP_W)) u_align (
      .din    (sml_pre),
      .amt    (diff),
      .dout   (sml_shift),
      .sticky (sml_sticky)
   );

   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = '0;
      spec_flags = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         spec_res   = QNAN;
         spec_flags = FLG_INVALID;
      end else if (a_inf) begin
         spec_res = {sa, INF_MAG};
      end else if (b_inf) begin
         spec_res = {sb, INF_MAG};
      end else if (a_zero && b_zero) begin
         spec_res   = {sa & sb, {(FW-1){1'b0}}};
         spec_flags = FLG_ZERO;
      end else if (a_zero) begin
         spec_res = {sb, b_q[FW-2:0]};
      end else if (b_zero) begin
         spec_res = a_q;
      end else begin
         spec_hit = 1'b0;
      end
   end

   assign sum = eff_sub_r ? (mant_r - mant_sml) : (mant_r + mant_sml);

   // mant_r layout: {carry, hidden, man, G, R, S}
   assign rnd_g   = mant_r[2];
   assign rnd_r   = mant_r[1];
   assign rnd_s   = mant_r[0];
   assign rnd_inc = rnd_g & (rnd_r | rnd_s | mant_r[3]);
   assign rnd     = {1'b0, mant_r[MW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
   assign exp_f   = rnd[MAN_W+1] ? exp_r + 1'b1 : exp_r;
   assign man_f   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
   assign rnd_ovf = (exp_f >= EXP_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         sign_r    <= 1'b0;
         eff_sub_r <= 1'b0;
         exp_r     <= '0;
         mant_r    <= '0;
         mant_sml  <= '0;
         result    <= '0;
         flags     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= op;
                  state <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (spec_hit) begin
                  result <= spec_res;
                  flags  <= spec_flags;
                  state  <= ST_DONE;
               end else begin
                  sign_r    <= a_big ? sa : sb;
                  eff_sub_r <= sa ^ sb;
                  exp_r     <= {1'b0, big_e};
                  mant_r    <= {2'b01, big_m, 3'b000};
                  mant_sml  <= {sml_shift[MW-1:1], sml_shift[0] | sml_sticky};
                  state     <= ST_ADD;
               end
            end
            ST_ADD: begin
               if (sum == '0) begin
                  result <= '0;
                  flags  <= FLG_ZERO;
                  state  <= ST_DONE;
               end else begin
                  mant_r <= sum;
                  state  <= ST_NORM;
               end
            end
            ST_NORM: begin
               if (mant_r[MW-1]) begin
                  mant_r <= {1'b0, mant_r[MW-1:2], mant_r[1] | mant_r[0]};
                  exp_r  <= exp_r + 1'b1;
                  state  <= ST_ROUND;
               end else if (mant_r[MW-2]) begin
                  state <= ST_ROUND;
               end else if (exp_r == (EXP_W+1)'(1)) begin
                  result <= {sign_r, {(FW-1){1'b0}}};
                  flags  <= FLG_INEXACT | FLG_ZERO;
                  state  <= ST_DONE;
               end else begin
                  mant_r <= mant_r << 1;
                  exp_r  <= exp_r - 1'b1;
               end
            end
            ST_ROUND: begin
               if (rnd_ovf) begin
                  result <= {sign_r, INF_MAG};
                  flags  <= FLG_OVERFLOW | FLG_INEXACT;
               end else begin
                  result <= {sign_r, exp_f[EXP_W-1:0], man_f};
                  flags  <= (rnd_g | rnd_r | rnd_s) ? FLG_INEXACT : 4'b0000;
               end
               state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq in binary16: exact-arithmetic reference
// model, per-vector literal expectations and latency, handshake and reset.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, op, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic [3:0]  flags;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] mdl_res   = '0;
   logic [3:0]  mdl_flags = '0;
   bit          mon_en    = 1'b0;

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Exact sum in units of 2^-24, then RNE to 11 significant bits.
   function automatic void fp_model(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                                    output logic [15:0] r, output logic [3:0] f);
      logic   sa, sb, neg;
      int     ea, eb, p, e, sh;
      longint ma, mb, va, vb, sum, mag, sig, rem, half;
      bit     inx;
      sa = ta[15];
      sb = tb[15] ^ top;
      ea = int'(ta[14:10]);
      eb = int'(tb[14:10]);
      ma = longint'(ta[9:0]);
      mb = longint'(tb[9:0]);
      r  = 16'h0000;
      f  = 4'b0000;
      if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0) || (ea == 31 && eb == 31 && sa != sb)) begin
         r = 16'h7E00; f = 4'b1000; return;
      end
      if (ea == 31) begin r = {sa, 15'h7C00}; return; end
      if (eb == 31) begin r = {sb, 15'h7C00}; return; end
      if (ea == 0 && eb == 0) begin r = {sa & sb, 15'h0000}; f = 4'b0001; return; end
      if (ea == 0) begin r = {sb, tb[14:0]}; return; end
      if (eb == 0) begin r = ta; return; end
      va  = (1024 + ma) << (ea - 1);
      vb  = (1024 + mb) << (eb - 1);
      sum = (sa ? -va : va) + (sb ? -vb : vb);
      if (sum == 0) begin f = 4'b0001; return; end
      neg = (sum < 0);
      mag = neg ? -sum : sum;
      if (mag < 1024) begin r = {neg, 15'h0000}; f = 4'b0011; return; end
      p = 0;
      for (int i = 0; i < 63; i++) if (mag[i]) p = i;
      e    = p - 9;
      sh   = p - 10;
      sig  = mag >> sh;
      rem  = mag - (sig << sh);
      half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
      inx  = (rem != 0);
      if (sh > 0 && (rem > half || (rem == half && sig[0]))) sig++;
      if (sig == 2048) begin sig = 1024; e++; end
      if (e >= 31) begin r = {neg, 15'h7C00}; f = 4'b0110; return; end
      r = {neg, 5'(e), 10'(sig)};
      f = {2'b00, inx, 1'b0};
   endfunction

   always @(negedge clk) begin
      if (mon_en && !reset && out_valid) begin
         check("mon_result", 32'(result), 32'(mdl_res));
         check("mon_flags", 32'(flags), 32'(mdl_flags));
         check("mon_in_ready_low", 32'(in_ready), 0);
      end
   end

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                         input logic [15:0] xr, input logic [3:0] xf, input int xlat,
                         input int hold, input logic [15:0] na, input logic [15:0] nb);
      logic [15:0] mr;
      logic [3:0]  mf;
      int          cyc;
      fp_model(ta, tb, top, mr, mf);
      check("pin_result", 32'(mr), 32'(xr));
      check("pin_flags", 32'(mf), 32'(xf));
      @(negedge clk);
      a = ta; b = tb; op = top; in_valid = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
      if (!in_ready) begin
         check("accept_wait", 32'(in_ready), 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      mdl_res   = mr;
      mdl_flags = mf;
      mon_en    = 1'b1;
      cyc = 1;
      while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
      if (!out_valid) begin
         check("done_wait", 32'(out_valid), 1);
         return;
      end
      check("latency", 32'(cyc), 32'(xlat));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         a = na; b = nb; op = 1'b0; in_valid = 1'b1;
         check("hold_in_ready", 32'(in_ready), 0);
         check("hold_out_valid", 32'(out_valid), 1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_out_valid", 32'(out_valid), 0);
      check("release_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      int seen;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_result", 32'(result), 0);
      check("rst_flags", 32'(flags), 0);
      reset = 1'b0;

      run_op(16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000,  5, 0, 16'h0, 16'h0);
      run_op(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0001,  3, 0, 16'h0, 16'h0);
      run_op(16'h3C01, 16'h3C00, 1'b1, 16'h1400, 4'b0000, 15, 0, 16'h0, 16'h0);
      run_op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0110,  5, 0, 16'h0, 16'h0);
      run_op(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000,  2, 0, 16'h0, 16'h0);
      run_op(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0010,  5, 0, 16'h0, 16'h0);
      run_op(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000,  2, 0, 16'h0, 16'h0);
      run_op(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 4'b0000,  2, 0, 16'h0, 16'h0);
      run_op(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 4'b0000,  2, 0, 16'h0, 16'h0);
      run_op(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0001,  2, 0, 16'h0, 16'h0);
      run_op(16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b0011,  4, 0, 16'h0, 16'h0);
      run_op(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000,  6, 0, 16'h0, 16'h0);
      run_op(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 4'b0000,  6, 0, 16'h0, 16'h0);
      run_op(16'h0001, 16'h3C00, 1'b0, 16'h3C00, 4'b0000,  2, 0, 16'h0, 16'h0);
      run_op(16'h3FFF, 16'h1000, 1'b0, 16'h4000, 4'b0010,  5, 0, 16'h0, 16'h0);
      // backpressure: second pair is presented during the hold, taken only after release
      run_op(16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000,  5, 5, 16'h3C00, 16'h3C00);
      run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000,  5, 0, 16'h0, 16'h0);
      run_op(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0010,  5, 0, 16'h0, 16'h0);

      // reset in the middle of a long cancellation
      mon_en = 1'b0;
      @(negedge clk);
      a = 16'h3C01; b = 16'h3C00; op = 1'b1; in_valid = 1'b1;
      check("abort_accept_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_in_ready", 32'(in_ready), 1);
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_result", 32'(result), 0);
      check("abort_flags", 32'(flags), 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_out_valid", 32'(seen), 0);
      run_op(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000,  6, 0, 16'h0, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
